geofence_point_sorter: RTL

//  Upstream stage of the geofence datapath. Collects the 6 receiver samples
//  (X, Y, R) of one object, one per handshake. Keeps receiver 0 as the anchor
//  and sorts receivers 1..5 counter-clockwise (Y-up) around it by cross

---
 rtl/geofence_point_sorter_if.sv | 29 ++
 rtl/geofence_point_sorter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/geofence_point_sorter_if.sv
// Sample-in / ordered-receiver-out stream bundle for the geofence point sorter.
// master drives samples in and accepts ordered receivers; slave is the sorter.
interface geofence_point_sorter_if #(
  parameter int XW = 10,
  parameter int RW = 11
);
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_X;
  logic [XW-1:0] in_Y;
  logic [RW-1:0] in_R;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] out_X;
  logic [XW-1:0] out_Y;
  logic [RW-1:0] out_R;
  logic [2:0]    out_idx;
  logic          out_last;

  modport master (
    output in_valid, in_X, in_Y, in_R, out_ready,
    input  in_ready, out_valid, out_X, out_Y, out_R, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_X, in_Y, in_R, out_ready,
    output in_ready, out_valid, out_X, out_Y, out_R, out_idx, out_last
  );
endinterface

// File: rtl/geofence_point_sorter.sv
// Collects six receiver samples, orders receivers 1..5 counter-clockwise about
// receiver 0 with a fixed 10-step bubble sort, then streams the hexagon out.
//
// state | meaning
// LOAD  | accepting samples into buf[0..5]
// SORT  | 10 compare-swap steps, then one cycle to present buf[0]
// OUT   | streaming buf[0..5] under out_valid/out_ready
module geofence_point_sorter #(
  parameter int NPTS = 6,
  parameter int XW   = 10,
  parameter int RW   = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  geofence_point_sorter_if.slave  pt,
  output logic                    busy_o
);
  localparam int CW = 2 * XW + 3;
  localparam logic [3:0] LAST_STEP = 4'd10;
  localparam logic [2:0] LAST_IDX  = 3'(NPTS - 1);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t        state_q;
  logic [2:0]    cnt_q;
  logic [3:0]    step_q;
  logic [XW-1:0] x_q [NPTS];
  logic [XW-1:0] y_q [NPTS];
  logic [RW-1:0] r_q [NPTS];
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          busy_q;
  logic [2:0]    out_idx_q;
  logic [XW-1:0] out_x_q;
  logic [XW-1:0] out_y_q;
  logic [RW-1:0] out_r_q;

  logic [2:0]    pi_d;
  logic [2:0]    pj_d;
  logic [CW-1:0] ax_d, ay_d, bx_d, by_d, cr_d;
  logic          swap_d;
  logic [2:0]    nidx_d;

  // Pass lengths 4,3,2,1 over pairs (i,i+1)
  always_comb begin
    pi_d = 3'd1;
    case (step_q)
      4'd0, 4'd4, 4'd7, 4'd9: pi_d = 3'd1;
      4'd1, 4'd5, 4'd8:       pi_d = 3'd2;
      4'd2, 4'd6:             pi_d = 3'd3;
      4'd3:                   pi_d = 3'd4;
      default:                pi_d = 3'd1;
    endcase
    pj_d = pi_d + 3'd1;
  end

  // Differences fit 11 bits and the cross product fits CW bits, so plain
  // CW-bit two's-complement arithmetic gives the exact signed result.
  always_comb begin
    ax_d   = {{(CW-XW){1'b0}}, x_q[pi_d]} - {{(CW-XW){1'b0}}, x_q[0]};
    ay_d   = {{(CW-XW){1'b0}}, y_q[pi_d]} - {{(CW-XW){1'b0}}, y_q[0]};
    bx_d   = {{(CW-XW){1'b0}}, x_q[pj_d]} - {{(CW-XW){1'b0}}, x_q[0]};
    by_d   = {{(CW-XW){1'b0}}, y_q[pj_d]} - {{(CW-XW){1'b0}}, y_q[0]};
    cr_d   = ax_d * by_d - bx_d * ay_d;
    swap_d = cr_d[CW-1];
    nidx_d = out_idx_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == LOAD && pt.in_valid) begin
        x_q[cnt_q] <= pt.in_X;
        y_q[cnt_q] <= pt.in_Y;
        r_q[cnt_q] <= pt.in_R;
      end else if (state_q == SORT && step_q != LAST_STEP && swap_d) begin
        x_q[pi_d] <= x_q[pj_d];
        y_q[pi_d] <= y_q[pj_d];
        r_q[pi_d] <= r_q[pj_d];
        x_q[pj_d] <= x_q[pi_d];
        y_q[pj_d] <= y_q[pi_d];
        r_q[pj_d] <= r_q[pi_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= 3'd0;
      step_q      <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_idx_q   <= 3'd0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_r_q     <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (pt.in_valid) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q      <= 3'd0;
              step_q     <= 4'd0;
              state_q    <= SORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        SORT: begin
          if (step_q == LAST_STEP) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
            out_x_q     <= x_q[0];
            out_y_q     <= y_q[0];
            out_r_q     <= r_q[0];
          end else begin
            step_q <= step_q + 4'd1;
          end
        end
        OUT: begin
          if (pt.out_ready) begin
            if (out_idx_q == LAST_IDX) begin
              state_q     <= LOAD;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_idx_q   <= 3'd0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              out_idx_q  <= nidx_d;
              out_last_q <= (nidx_d == LAST_IDX);
              out_x_q    <= x_q[nidx_d];
              out_y_q    <= y_q[nidx_d];
              out_r_q    <= r_q[nidx_d];
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign pt.in_ready  = in_ready_q;
  assign pt.out_valid = out_valid_q;
  assign pt.out_last  = out_last_q;
  assign pt.out_idx   = out_idx_q;
  assign pt.out_X     = out_x_q;
  assign pt.out_Y     = out_y_q;
  assign pt.out_R     = out_r_q;
  assign busy_o       = busy_q;
endmodule
